// File: rtl/ps2_keyboard_receiver_if.sv
// Decoded-keyboard output bundle shared between the PS/2 receiver and its consumers.
interface ps2_keyboard_receiver_if;
    logic [7:0] oScanCode;
    logic       oValid;
    logic       oBreak;
    logic       oExtended;
    logic       oParityError;
    logic       oFrameError;
    logic       oBusy;

    modport master (
        output oScanCode, oValid, oBreak, oExtended,
        output oParityError, oFrameError, oBusy
    );

    modport slave (
        input oScanCode, oValid, oBreak, oExtended,
        input oParityError, oFrameError, oBusy
    );
endinterface

// File: rtl/ps2_keyboard_receiver.sv
// Host-side PS/2 keyboard receiver: deserialises 11-bit frames, checks framing and
// odd parity, folds E0/F0 prefixes into flags and emits one scancode per key event.
module ps2_keyboard_receiver #(
    parameter int TIMEOUT = 5000,
    parameter int CNT_W   = 13
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         iPS2Clk,
    input  logic                         iPS2Data,
    ps2_keyboard_receiver_if.master      kb
);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    state_t           state, state_next;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev;
    logic             fe, data_s, timeout;
    logic [9:0]       shift;
    logic [3:0]       bitcnt;
    logic [CNT_W-1:0] wd;
    logic             brk_flag, ext_flag, brk_flag_d, ext_flag_d;
    logic [7:0]       scan_q, scan_d;
    logic             break_q, break_d, ext_q, ext_d;
    logic             valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

    // Synchronisers and edge history start high so leaving reset never looks like an edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], iPS2Clk};
            data_sync <= {data_sync[0], iPS2Data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fe      = clk_prev & ~clk_sync[1];
    assign data_s  = data_sync[1];
    assign timeout = (wd == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (fe && !data_s) state_next = RECV;
            RECV: begin
                if (fe && bitcnt == 4'd10) state_next = CHECK;
                else if (!fe && timeout)   state_next = IDLE;
            end
            CHECK: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bits enter at the top so after ten shifts: [7:0] data, [8] parity, [9] stop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            shift  <= '0;
            bitcnt <= '0;
            wd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fe && !data_s) begin
                        bitcnt <= 4'd1;
                        wd     <= '0;
                    end
                end
                RECV: begin
                    if (fe) begin
                        shift  <= {data_s, shift[9:1]};
                        bitcnt <= bitcnt + 4'd1;
                        wd     <= '0;
                    end else if (timeout) begin
                        bitcnt <= '0;
                        wd     <= '0;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                CHECK:   bitcnt <= '0;
                default: bitcnt <= '0;
            endcase
        end
    end

    always_comb begin
        scan_d     = scan_q;
        break_d    = break_q;
        ext_d      = ext_q;
        valid_d    = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        brk_flag_d = brk_flag;
        ext_flag_d = ext_flag;
        case (state)
            IDLE: if (fe && data_s) ferr_d = 1'b1;
            RECV: if (!fe && timeout) ferr_d = 1'b1;
            CHECK: begin
                if (!shift[9]) begin
                    ferr_d     = 1'b1;
                    brk_flag_d = 1'b0;
                    ext_flag_d = 1'b0;
                end else if (^shift[8:0] != 1'b1) begin
                    perr_d     = 1'b1;
                    brk_flag_d = 1'b0;
                    ext_flag_d = 1'b0;
                end else if (shift[7:0] == 8'hE0) begin
                    ext_flag_d = 1'b1;
                end else if (shift[7:0] == 8'hF0) begin
                    brk_flag_d = 1'b1;
                end else begin
                    scan_d     = shift[7:0];
                    break_d    = brk_flag;
                    ext_d      = ext_flag;
                    valid_d    = 1'b1;
                    brk_flag_d = 1'b0;
                    ext_flag_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            scan_q   <= '0;
            break_q  <= 1'b0;
            ext_q    <= 1'b0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
        end else begin
            scan_q   <= scan_d;
            break_q  <= break_d;
            ext_q    <= ext_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            brk_flag <= brk_flag_d;
            ext_flag <= ext_flag_d;
        end
    end

    assign kb.oScanCode    = scan_q;
    assign kb.oBreak       = break_q;
    assign kb.oExtended    = ext_q;
    assign kb.oValid       = valid_q;
    assign kb.oParityError = perr_q;
    assign kb.oFrameError  = ferr_q;
    assign kb.oBusy        = (state != IDLE);

endmodule

// File: doc/ps2_keyboard_receiver.md
Name: ps2_keyboard_receiver

Overview:
Host-side PS/2 receiver: the receiving end of the keyboard link that the SP2 device side drives.
- Samples the keyboard's PS/2 clock and data lines in the system Clock domain and deserialises 11-bit frames.
- Checks start, odd parity and stop bits.
- Folds E0/F0 prefix bytes into flags and presents one validated scancode per key event to downstream logic, such as the VGA character/colour path.

Parameters:
TIMEOUT, 5000, Clock cycles allowed between consecutive PS/2 falling edges inside a frame before the frame is aborted (200 us at 25 MHz).
CNT_W, 13, width of the inter-edge watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
Clock  input  1  system clock (25 MHz pixel clock domain).
Reset  input  1  synchronous, active-high reset.
iPS2Clk  input  1  raw PS/2 clock from the keyboard, asynchronous, idle high.
iPS2Data  input  1  raw PS/2 data from the keyboard, asynchronous, idle high.
oScanCode  output  8  last accepted scancode byte (prefixes excluded).
oValid  output  1  one-cycle strobe: oScanCode/oBreak/oExtended updated.
oBreak  output  1  key-release flag for current oScanCode (F0 prefix seen).
oExtended  output  1  extended-key flag for current oScanCode (E0 prefix seen).
oParityError  output  1  one-cycle strobe: frame failed the odd-parity check.
oFrameError  output  1  one-cycle strobe: bad start bit, bad stop bit, or watchdog timeout.
oBusy  output  1  high while a frame is being received (RECV or CHECK).

Behaviour:
Reset and clock:
- Reset is synchronous, active-high; clock is Clock.
- Reset values: oScanCode=0, oValid=0, oBreak=0, oExtended=0, oParityError=0, oFrameError=0, oBusy=0, state=IDLE.
- Reset also clears: prefix flags, bit counter, shift register and watchdog.
- Reset sets both synchroniser chains and the previous-clock register to 1, so no spurious edge occurs after reset.

Input conditioning:
- 2-FF synchroniser on each of iPS2Clk and iPS2Data.
- A falling edge (fe) is detected when the previous synchronised clock is 1 and the current one is 0.
- Data is sampled from the synchronised data in the same cycle fe is seen.

States: IDLE, RECV, CHECK.

IDLE:
- fe with data=0 (start bit): load bitcnt=1, clear watchdog, go to RECV.
- fe with data=1: pulse oFrameError, stay in IDLE.

RECV:
- Each fe shifts data in LSB first: bits 1-8 are data, bit 9 is parity, bit 10 is stop.
- Each fe increments bitcnt and clears the watchdog.
- The fe that captures bit 10 moves to CHECK.
- Without an fe, the watchdog increments. When the watchdog reaches TIMEOUT-1: pulse oFrameError, clear bitcnt, go to IDLE, discard the partial frame. Prefix flags are kept.

CHECK (exactly one cycle, then IDLE):
- If stop=0: pulse oFrameError, clear prefix flags.
- Else if XOR(data[7:0], parity) != 1: pulse oParityError, clear prefix flags.
- Else if byte=0xE0: set ext flag, no oValid.
- Else if byte=0xF0: set break flag, no oValid.
- Else: oScanCode<=byte, oBreak<=break flag, oExtended<=ext flag, pulse oValid, clear both flags.

Timing and output rules:
- Latency: fe of bit 10 is detected in cycle N (CHECK entered at N+1); strobes and data are visible in cycle N+2.
- All strobes are exactly one cycle wide. At most one strobe fires per frame.
- oScanCode, oBreak and oExtended hold their values until the next oValid.
- oBusy=1 in RECV and CHECK, 0 in IDLE.
- An fe arriving during CHECK is ignored; the PS/2 frame spacing guarantees none occurs.
- Reset asserted mid-frame aborts the frame silently, with no strobes.
- No host-to-device transmission: both PS/2 lines are inputs only.

Test Plan:
Bench conventions: PS/2 half-period 20 Clock cycles; TIMEOUT overridden to 200; data changes mid-high phase.
1. Single make code 0x1C, bits 0,0,0,1,1,1,0,0,0,0,1 -> oValid one pulse, oScanCode=0x1C, oBreak=0, oExtended=0, no error strobes, oBusy low after CHECK.
2. Break sequence F0 then 1C -> no oValid after F0. One oValid after 1C with oScanCode=0x1C, oBreak=1, oExtended=0. A following 0x32 frame gives oBreak=0.
3. Extended break E0, F0, 74 -> exactly one oValid, oScanCode=0x74, oBreak=1, oExtended=1. Both flags are cleared afterwards.
4. 0x1C sent with parity bit=1 -> oParityError one pulse, no oValid, oScanCode unchanged. Next frame 0x32 (parity 0) decodes normally.
5. Frame with stop bit=0, then a frame with start bit=1 -> oFrameError pulses once per frame. The following valid 0x1C decodes.
6. Send 5 bits then hold iPS2Clk high -> oFrameError pulses 200 cycles after the last fe, oBusy drops. Separately, assert Reset after 6 bits -> no strobes, all outputs 0. Next 0x1C frame decodes correctly.
